button_event_decoder: RTL and testbench

Converts a raw, bouncing push-button input into clean, classified single-cycle events: short press, long press, and auto-repeat while held. It receives the button signal that the debounce path otherwise turns into a bare edge pulse, and produces per-gesture events for the control logic (velocity-curve parameter up/down, mode select). It contains its own synchronizer and stable-count debouncer, so no slow clock is needed and all logic runs in the single system clock domain.

---
 rtl/button_event_decoder.sv | 121 ++++++++++++
 tb/tb_button_event_decoder.sv | 139 +++++++++++++
 2 files changed

// File: rtl/button_event_decoder.sv
// Raw push-button to clean single-cycle short/long/repeat events, with an internal 2-flop synchronizer and stable-count debouncer.
// Latency: pressed follows pb_in by 2+STABLE_CYCLES cycles; events are registered one cycle after the deciding pressed value.
module button_event_decoder #(
  parameter int STABLE_CYCLES = 16,
  parameter int LONG_CYCLES   = 1024,
  parameter int REPEAT_CYCLES = 256,
  parameter int CNT_W         = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic pb_in,
  output logic pressed,
  output logic short_press,
  output logic long_press,
  output logic repeat_pulse
);

  typedef enum logic [1:0] {IDLE, PRESS, HOLD} state_t;

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] stable_cnt_q, stable_cnt_d;
  logic             pressed_q, pressed_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;

  always_comb begin
    sync1_d      = pb_in;
    sync2_d      = sync1_q;
    stable_cnt_d = '0;
    pressed_d    = pressed_q;
    if (sync2_q != pressed_q) begin
      if (stable_cnt_q == STABLE_LAST) begin
        pressed_d = ~pressed_q;
      end else begin
        stable_cnt_d = stable_cnt_q + 1'b1;
      end
    end
  end

  // FSM watches the registered debounced level, so events lag pressed by one cycle.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    rep_cnt_d  = rep_cnt_q;
    short_d    = 1'b0;
    long_d     = 1'b0;
    repeat_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pressed_q) begin
          state_d    = PRESS;
          hold_cnt_d = CNT_W'(1);
        end
      end
      PRESS: begin
        if (!pressed_q) begin
          short_d = 1'b1;
          state_d = IDLE;
        end else if (hold_cnt_q == LONG_LAST) begin
          long_d    = 1'b1;
          state_d   = HOLD;
          rep_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (!pressed_q) begin
          state_d = IDLE;
        end else if (rep_cnt_q == REPEAT_LAST) begin
          repeat_d  = 1'b1;
          rep_cnt_d = '0;
        end else begin
          rep_cnt_d = rep_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      stable_cnt_q <= '0;
      pressed_q    <= 1'b0;
      state_q      <= IDLE;
      hold_cnt_q   <= '0;
      rep_cnt_q    <= '0;
      short_q      <= 1'b0;
      long_q       <= 1'b0;
      repeat_q     <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      stable_cnt_q <= stable_cnt_d;
      pressed_q    <= pressed_d;
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      rep_cnt_q    <= rep_cnt_d;
      short_q      <= short_d;
      long_q       <= long_d;
      repeat_q     <= repeat_d;
    end
  end

  assign pressed      = pressed_q;
  assign short_press  = short_q;
  assign long_press   = long_q;
  assign repeat_pulse = repeat_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder: directed gestures plus random bounce, checked every cycle against a gesture-level model.
module tb_button_event_decoder;
  localparam int STABLE = 4;
  localparam int LONG   = 20;
  localparam int REPEAT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pb_in = 1'b0;
  logic pressed, short_press, long_press, repeat_pulse;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: sync pipeline, recent sync2 history, debounced level and high-run age.
  bit m_s1, m_s2, m_pressed;
  bit m_hist[STABLE];
  int m_age, m_prev_age;
  bit e_short, e_long, e_rep;

  button_event_decoder #(
    .STABLE_CYCLES(STABLE), .LONG_CYCLES(LONG), .REPEAT_CYCLES(REPEAT), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .pb_in(pb_in), .pressed(pressed),
    .short_press(short_press), .long_press(long_press), .repeat_pulse(repeat_pulse)
  );

  always #5 clk = ~clk;

  task automatic model_step(input bit r, input bit p);
    bit all_diff;
    bit new_pressed;
    if (r) begin
      m_s1 = 0; m_s2 = 0; m_pressed = 0; m_age = 0; m_prev_age = 0;
      for (int i = 0; i < STABLE; i++) m_hist[i] = 0;
      e_short = 0; e_long = 0; e_rep = 0;
    end else begin
      // Events are decided by the debounced level's run length in the current cycle.
      e_short = !m_pressed && m_prev_age >= 1 && m_prev_age < LONG;
      e_long  = m_pressed && m_age == LONG;
      e_rep   = m_pressed && m_age > LONG && ((m_age - LONG) % REPEAT) == 0;
      for (int i = STABLE - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = m_s2;
      all_diff = 1;
      for (int i = 0; i < STABLE; i++) if (m_hist[i] == m_pressed) all_diff = 0;
      new_pressed = all_diff ? !m_pressed : m_pressed;
      m_pressed = new_pressed;
      m_s2 = m_s1;
      m_s1 = p;
      m_prev_age = m_age;
      m_age = new_pressed ? m_age + 1 : 0;
    end
  endtask

  task automatic step(input bit r, input bit p);
    rst = r;
    pb_in = p;
    @(posedge clk);
    model_step(r, p);
    #1;
    n_assert++;
    assert (pressed === m_pressed) else begin
      n_fail++; $error("FAIL pressed: got %b want %b at %0t", pressed, m_pressed, $time);
    end
    n_assert++;
    assert (short_press === e_short) else begin
      n_fail++; $error("FAIL short_press: got %b want %b at %0t", short_press, e_short, $time);
    end
    n_assert++;
    assert (long_press === e_long) else begin
      n_fail++; $error("FAIL long_press: got %b want %b at %0t", long_press, e_long, $time);
    end
    n_assert++;
    assert (repeat_pulse === e_rep) else begin
      n_fail++; $error("FAIL repeat_pulse: got %b want %b at %0t", repeat_pulse, e_rep, $time);
    end
    n_assert++;
    assert ((32'(short_press) + 32'(long_press) + 32'(repeat_pulse)) <= 1) else begin
      n_fail++; $error("FAIL onehot: got s%b l%b r%b want at most one", short_press, long_press, repeat_pulse);
    end
  endtask

  task automatic run(input bit p, input int n);
    for (int i = 0; i < n; i++) step(1'b0, p);
  endtask

  task automatic bounce(input int ncyc, input int maxrun, input bit start);
    bit lvl;
    int done;
    int len;
    lvl = start;
    done = 0;
    while (done < ncyc) begin
      len = $urandom_range(maxrun, 1);
      run(lvl, len);
      done += len;
      lvl = !lvl;
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    run(1'b0, 5);
    // Bounce rejection: runs never reach STABLE at sync2.
    bounce(40, 3, 1'b1);
    run(1'b0, 15);
    // Short press, then both sides of the long threshold.
    run(1'b1, 10);  run(1'b0, 30);
    run(1'b1, 19);  run(1'b0, 30);
    run(1'b1, 20);  run(1'b0, 30);
    // Long press with repeats, released just after the third repeat.
    run(1'b1, 45);  run(1'b0, 30);
    // Reset mid-hold with the button still down.
    run(1'b1, 2 + STABLE + 10);
    step(1'b1, 1'b1); step(1'b1, 1'b1);
    run(1'b1, 40);  run(1'b0, 30);
    // Bouncy release after a long press: fixed 3-cycle runs.
    run(1'b1, 30);
    for (int i = 0; i < 6; i++) run(i % 2 == 0 ? 1'b0 : 1'b1, 3);
    run(1'b0, 30);
    // Back-to-back clean gestures without extra idle gap.
    run(1'b1, 8); run(1'b0, STABLE); run(1'b1, 25); run(1'b0, STABLE);
    run(1'b1, 3); run(1'b0, 30);
    // Random gestures with bouncy edges and random hold lengths.
    for (int g = 0; g < 25; g++) begin
      bounce($urandom_range(12, 0), 3, 1'b1);
      run(1'b1, $urandom_range(70, 1));
      bounce($urandom_range(12, 0), 3, 1'b0);
      run(1'b0, $urandom_range(20, 8));
      if ($urandom_range(9, 0) == 0) begin
        step(1'b1, 1'b1);
      end
    end
    run(1'b0, 20);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
